uart_tx_mmio: RTL and testbench
===============================

Name: uart_tx_mmio

Overview:
Memory-mapped UART transmitter on the processor's data-memory bus. It sits downstream of the data path and consumes store words (ALU result as address, ReadData2 as write data). Bytes go into a small TX FIFO and are serialized 8N1 on a single output line. A status register is readable by load instructions; the integrator muxes its ReadData with DataMemory's ReadData on address decode.

Parameters:
CLKS_PER_BIT, 434, clock cycles per serial bit (50 MHz / 115200); legal range is 2 or more.
FIFO_DEPTH, 4, TX FIFO entries; must be a power of two, 2 to 16.
BASE_ADDR, 32'h1001_0040, byte address of the DATA register; STATUS is at BASE_ADDR+4.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
reset  input  1  synchronous, active-low reset; sampled on the clk rising edge.
Address  input  32  byte address from the ALU result.
WriteData  input  32  store data from register rt.
MemWrite  input  1  store strobe; one transfer per cycle while high.
MemRead  input  1  load strobe.
ReadData  output  32  status read data; combinational.
UartTx  output  1  serial line; idles high.
TxBusy  output  1  high while a frame is on the line or the FIFO is non-empty.

Behaviour:
- Reset (reset==0 at an edge):
  - FIFO emptied; count=0; overflow=0.
  - FSM goes to IDLE; UartTx=1; bit and baud counters=0.
  - This applies mid-frame too: the line returns high after that edge, and the partial frame is abandoned.
- Decode is exact on all 32 address bits:
  - DATA write: MemWrite && Address==BASE_ADDR.
  - STATUS write: MemWrite && Address==BASE_ADDR+4.
  - STATUS read: MemRead && Address==BASE_ADDR+4.
  - Any other address: no effect.
- STATUS format:
  - bit0 full (count==FIFO_DEPTH).
  - bit1 empty (count==0).
  - bit2 busy (FSM != IDLE).
  - bit3 overflow (sticky).
  - bits[8:4] count.
  - all other bits 0.
- ReadData equals STATUS during a STATUS read, otherwise 32'h0. There is no read side effect.
- Push on a DATA write stores WriteData[7:0]; upper bits are ignored.
  - Accepted if not full, or if a pop occurs at the same edge. On simultaneous push and pop at full, count stays FIFO_DEPTH.
  - Otherwise the byte is dropped and overflow is set to 1 at that edge.
- Overflow is cleared by a STATUS write with WriteData[3]==1. If a clear and a new overflow happen at the same edge, the set wins.
- FIFO is circular with read and write pointers of log2(FIFO_DEPTH) bits; pointers wrap naturally.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: UartTx=1. If FIFO is non-empty at an edge, pop the head into the shift register, clear the baud counter and go to START.
  - START: UartTx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: UartTx=shift[0] for CLKS_PER_BIT cycles per bit, LSB first. Shift right after each bit. After bit index 7 completes, go to STOP.
  - STOP: UartTx=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Timing:
  - Latency: a DATA write at edge N makes the FIFO non-empty after N. The pop happens at edge N+1, and UartTx falls after edge N+1.
  - A frame lasts exactly 10*CLKS_PER_BIT cycles. Back-to-back frames are separated by exactly one IDLE cycle.
- UartTx is driven from a register, so it is glitch-free.
- TxBusy = (state != IDLE) || !empty.

Test Plan:
1. CLKS_PER_BIT=4. Hold reset=0 for 2 cycles, then 1. UartTx=1 and TxBusy=0; a STATUS read returns 32'h0000_0002.
2. Store 32'hABCD_0055 to BASE_ADDR at edge N. UartTx falls after edge N+1 and shows 0,1,0,1,0,1,0,1,0,1, each bit exactly 4 cycles. TxBusy drops after edge N+41.
3. Store 5 bytes (0x01..0x05) in consecutive cycles with FIFO_DEPTH=4, while a frame is already active.
   - If the head was popped, all 5 are accepted and overflow=0.
   - Repeat from IDLE with 6 bytes: the last is dropped and STATUS bit3=1.
   - STATUS write with 32'h8 clears bit3.
4. Fill the FIFO to full, then store at the edge where the FSM pops. The byte is accepted and count stays 4. The frames on the line are in push order, with 1 idle cycle between frames.
5. Pull reset low during DATA bit 3 for one edge. UartTx=1 after that edge, STATUS=32'h2, and no further frames are sent.
6. Store to BASE_ADDR+8 and read BASE_ADDR. No FIFO change, ReadData=0, UartTx stays 1.

Source files
------------

// File: rtl/uart_tx_mmio.sv
// uart_tx_mmio: store-driven 8N1 UART transmitter on the data-memory bus,
// with a small TX FIFO and a load-readable STATUS word.
module uart_tx_mmio #(
   parameter int          CLKS_PER_BIT = 434,
   parameter int          FIFO_DEPTH   = 4,
   parameter logic [31:0] BASE_ADDR    = 32'h1001_0040
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Address,
   input  logic [31:0] WriteData,
   input  logic        MemWrite,
   input  logic        MemRead,
   output logic [31:0] ReadData,
   output logic        UartTx,
   output logic        TxBusy
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } txStateT;

   txStateT       state, stateNext;
   logic [BW-1:0] baud, baudNext;
   logic [2:0]    bitIdx, bitIdxNext;
   logic [7:0]    shiftReg, shiftNext;
   logic          txReg, txNext;
   logic          bitDone;

   logic [7:0]    fifoMem [FIFO_DEPTH];
   logic [PW-1:0] rdPtr, wrPtr;
   logic [CW-1:0] count;
   logic          overflow;
   logic          full, empty;
   logic          dataWr, statusWr, statusRd;
   logic          push, pop, drop;
   logic [31:0]   status;
   logic          unusedWd;

   assign dataWr   = MemWrite && (Address == BASE_ADDR);
   assign statusWr = MemWrite && (Address == STATUS_ADDR);
   assign statusRd = MemRead && (Address == STATUS_ADDR);

   assign full  = (count == COUNT_FULL);
   assign empty = (count == '0);

   // A pop at the same edge frees a slot, so a store into a full FIFO still lands
   assign push = dataWr && (!full || pop);
   assign drop = dataWr && !push;

   assign unusedWd = ^WriteData[31:8];

   always_ff @(posedge clk) begin
      if (!reset) begin
         rdPtr    <= '0;
         wrPtr    <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push)
            wrPtr <= wrPtr + PW'(1);
         if (pop)
            rdPtr <= rdPtr + PW'(1);
         count <= count + CW'(push) - CW'(pop);
         if (drop)
            overflow <= 1'b1;
         else if (statusWr && WriteData[3])
            overflow <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         fifoMem[wrPtr] <= WriteData[7:0];
   end

   assign bitDone = (baud == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= IDLE;
         baud     <= '0;
         bitIdx   <= '0;
         shiftReg <= '0;
         txReg    <= 1'b1;
      end else begin
         state    <= stateNext;
         baud     <= baudNext;
         bitIdx   <= bitIdxNext;
         shiftReg <= shiftNext;
         txReg    <= txNext;
      end
   end

   always_comb begin
      stateNext  = state;
      baudNext   = baud + BW'(1);
      bitIdxNext = bitIdx;
      shiftNext  = shiftReg;
      pop        = 1'b0;
      unique case (state)
         IDLE: begin
            baudNext = '0;
            if (!empty) begin
               pop       = 1'b1;
               shiftNext = fifoMem[rdPtr];
               stateNext = START;
            end
         end
         START: begin
            if (bitDone) begin
               stateNext  = DATA;
               baudNext   = '0;
               bitIdxNext = '0;
            end
         end
         DATA: begin
            if (bitDone) begin
               baudNext = '0;
               if (bitIdx == 3'd7) begin
                  stateNext = STOP;
               end else begin
                  bitIdxNext = bitIdx + 3'd1;
                  shiftNext  = shiftReg >> 1;
               end
            end
         end
         STOP: begin
            if (bitDone) begin
               stateNext = IDLE;
               baudNext  = '0;
            end
         end
         default: begin
            stateNext = IDLE;
            baudNext  = '0;
         end
      endcase

      // Line level follows the state being entered, so UartTx is a flop output
      txNext = 1'b1;
      unique case (1'b1)
         (stateNext == START): txNext = 1'b0;
         (stateNext == DATA):  txNext = shiftNext[0];
         default:              txNext = 1'b1;
      endcase
   end

   assign status = {23'd0, 5'(count), overflow,
                    (state != IDLE), empty, full};

   assign ReadData = statusRd ? status : 32'h0;
   assign UartTx   = txReg;
   assign TxBusy   = (state != IDLE) || !empty;

endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb_uart_tx_mmio: directed stores and loads against a frame-level model
// of the UART line, FIFO occupancy and STATUS word.
module tb_uart_tx_mmio;

   localparam int C = 4;
   localparam int D = 4;
   localparam logic [31:0] BASE = 32'h1001_0040;
   localparam logic [31:0] STAT = BASE + 32'd4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic        MemWrite;
   logic        MemRead;
   logic [31:0] ReadData;
   logic        UartTx;
   logic        TxBusy;

   uart_tx_mmio #(
      .CLKS_PER_BIT(C),
      .FIFO_DEPTH(D),
      .BASE_ADDR(BASE)
   ) dut (
      .clk(clk),
      .reset(reset),
      .Address(Address),
      .WriteData(WriteData),
      .MemWrite(MemWrite),
      .MemRead(MemRead),
      .ReadData(ReadData),
      .UartTx(UartTx),
      .TxBusy(TxBusy)
   );

   always #5 clk = ~clk;

   int nCmp = 0;
   int nBad = 0;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nBad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: pending bytes, and the byte on the line with cycles since its start bit
   logic [7:0] q[$];
   bit         active = 1'b0;
   int         pos = 0;
   logic [7:0] cur = 8'h00;
   bit         ovf = 1'b0;

   function automatic logic frameBit(input logic [7:0] b, input int k);
      if (k == 0)
         return 1'b0;
      if (k <= 8)
         return b[k-1];
      return 1'b1;
   endfunction

   always @(negedge clk) begin
      logic        expTx;
      logic        expBusy;
      logic [31:0] expSt;
      logic [31:0] expRd;
      bit          popNow;
      bit          wasFull;

      expTx   = active ? frameBit(cur, pos / C) : 1'b1;
      expBusy = active || (q.size() != 0);
      expSt   = 32'(q.size() * 16 + int'(ovf) * 8 + int'(active) * 4
                    + int'(q.size() == 0) * 2 + int'(q.size() == D));
      expRd   = (MemRead && Address == STAT) ? expSt : 32'h0;
      check("line", {31'd0, UartTx}, {31'd0, expTx});
      check("busy", {31'd0, TxBusy}, {31'd0, expBusy});
      check("rdata", ReadData, expRd);

      if (!reset) begin
         q.delete();
         ovf    = 1'b0;
         active = 1'b0;
         pos    = 0;
      end else begin
         popNow  = !active && (q.size() != 0);
         wasFull = (q.size() == D);
         if (active) begin
            if (pos == 10 * C - 1)
               active = 1'b0;
            else
               pos++;
         end
         if (popNow) begin
            cur    = q.pop_front();
            active = 1'b1;
            pos    = 0;
         end
         if (MemWrite && Address == STAT && WriteData[3])
            ovf = 1'b0;
         if (MemWrite && Address == BASE) begin
            if (!wasFull || popNow)
               q.push_back(WriteData[7:0]);
            else
               ovf = 1'b1;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d);
      Address   = a;
      WriteData = d;
      MemWrite  = 1'b1;
      tick();
      MemWrite  = 1'b0;
      Address   = 32'h0;
      WriteData = 32'h0;
   endtask

   task automatic rdChk(input string name, input logic [31:0] a,
                        input logic [31:0] exp);
      Address = a;
      MemRead = 1'b1;
      #1;
      check(name, ReadData, exp);
      MemRead = 1'b0;
      Address = 32'h0;
   endtask

   task automatic drain();
      for (int i = 0; i < 2000 && TxBusy; i++)
         tick();
      check("drain", {31'd0, TxBusy}, 32'd0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [9:0] frm;
      reset     = 1'b0;
      Address   = 32'h0;
      WriteData = 32'h0;
      MemWrite  = 1'b0;
      MemRead   = 1'b0;
      tick();
      tick();
      reset = 1'b1;

      // 1: reset state
      check("t1 line", {31'd0, UartTx}, 32'd1);
      check("t1 busy", {31'd0, TxBusy}, 32'd0);
      rdChk("t1 status", STAT, 32'h0000_0002);
      tick();

      // 2: single frame of 0x55, start bit then LSB first then stop
      frm = 10'h2AA;
      store(BASE, 32'hABCD_0055);
      check("t2 pre", {31'd0, UartTx}, 32'd1);
      tick();
      for (int k = 0; k < 10; k++) begin
         for (int j = 0; j < C; j++) begin
            check("t2 bit", {31'd0, UartTx}, {31'd0, frm[k]});
            if (k == 9 && j == C - 1)
               check("t2 busyEnd", {31'd0, TxBusy}, 32'd1);
            tick();
         end
      end
      check("t2 idle", {31'd0, TxBusy}, 32'd0);
      check("t2 lineIdle", {31'd0, UartTx}, 32'd1);
      tick();

      // 3: five stores while a frame runs, then six from idle
      for (int b = 1; b <= 5; b++)
         store(BASE, 32'(b));
      rdChk("t3 five", STAT, 32'h45);
      drain();
      for (int b = 1; b <= 6; b++)
         store(BASE, 32'(b));
      rdChk("t3 six", STAT, 32'h4D);
      store(STAT, 32'h8);
      rdChk("t3 clr", STAT, 32'h45);
      drain();

      // 4: store into a full FIFO at the pop edge
      store(BASE, 32'hA1);
      store(BASE, 32'hB2);
      store(BASE, 32'hC3);
      store(BASE, 32'hD4);
      store(BASE, 32'hE5);
      rdChk("t4 full", STAT, 32'h45);
      repeat (37) tick();
      check("t4 gap", {31'd0, UartTx}, 32'd1);
      store(BASE, 32'hF6);
      rdChk("t4 stay", STAT, 32'h45);
      drain();

      // 5: reset in the middle of data bit 3
      store(BASE, 32'h33);
      store(BASE, 32'h99);
      repeat (16) tick();
      check("t5 bit3", {31'd0, UartTx}, 32'd0);
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("t5 line", {31'd0, UartTx}, 32'd1);
      check("t5 busy", {31'd0, TxBusy}, 32'd0);
      rdChk("t5 status", STAT, 32'h2);
      for (int i = 0; i < 60; i++) begin
         if (UartTx !== 1'b1)
            check("t5 quiet", {31'd0, UartTx}, 32'd1);
         tick();
      end
      check("t5 quietEnd", {31'd0, UartTx}, 32'd1);

      // 6: stray addresses
      store(BASE + 32'd8, 32'h77);
      rdChk("t6 rdBase", BASE, 32'h0);
      rdChk("t6 status", STAT, 32'h2);
      repeat (8) tick();
      check("t6 line", {31'd0, UartTx}, 32'd1);
      check("t6 busy", {31'd0, TxBusy}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
